// File: rtl/door_pkg.sv
// Shared types and default timing for the door motion sequencer.
// Pure declarations: no logic, no latency, no flow control.
package door_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MV_UP = 3'd1,
        MV_DN = 3'd2,
        PAUSE = 3'd3,
        FAULT = 3'd4
    } door_state_t;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } door_dir_t;

    localparam int DEAD_CYCLES_DEF    = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1000;
    localparam int DWELL_CYCLES_DEF   = 500;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/door_cycle_timer.sv
// Saturating cycle counter with synchronous clear and a count >= limit flag.
// Latency: count updates one edge after enable; flag is combinational from the count.
// Backpressure: none; enable low simply holds the count.
module door_cycle_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count >= limit);

endmodule

// File: rtl/door_motion_sequencer.sv
// Door motor sequencer: edge-detected requests, limits, obstacle reopen, dead-time reversal, timeout fault.
// Latency: motor outputs change on the edge that samples the request (Moore outputs of the state register).
// Backpressure: none; requests in PAUSE/FAULT are dropped. AUTO_CLOSE_EN adds dwell-timed auto-close.
module door_motion_sequencer
    import door_pkg::*;
#(
    parameter int DEAD_CYCLES    = DEAD_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int DWELL_CYCLES   = DWELL_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic Act_Wall,
    input  logic Act_Remote,
    input  logic UP_Max,
    input  logic DN_MAX,
    input  logic Obstacle,
    output logic UP_M,
    output logic DN_M,
    output logic Fault
);

    localparam int CNT_W = $clog2(max3(DEAD_CYCLES, TIMEOUT_CYCLES, DWELL_CYCLES) + 1) + 1;

    door_state_t      state, state_nxt;
    door_dir_t        last_dir, pause_dir, pause_dir_nxt;
    logic             wall_q, remote_q, armed;
    logic             req_evt, both_lim, dwell_ok;
    logic             tmr_clr, tmr_en, tmr_hit;
    logic [CNT_W-1:0] tmr_lim;

    // armed stays low for the first edge after reset so a request already held high is not an event
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wall_q   <= 1'b0;
            remote_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            wall_q   <= Act_Wall;
            remote_q <= Act_Remote;
            armed    <= 1'b1;
        end
    end

    assign req_evt  = armed & ((Act_Wall & ~wall_q) | (Act_Remote & ~remote_q));
    assign both_lim = UP_Max & DN_MAX;

`ifdef AUTO_CLOSE_EN
    assign dwell_ok = UP_Max & ~Obstacle;
`else
    assign dwell_ok = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            last_dir  <= DIR_DN;
            pause_dir <= DIR_UP;
        end else begin
            state     <= state_nxt;
            pause_dir <= pause_dir_nxt;
            if (state_nxt == MV_UP) begin
                last_dir <= DIR_UP;
            end else if (state_nxt == MV_DN) begin
                last_dir <= DIR_DN;
            end
        end
    end

    // One shared timer: count >= limit marks the last PAUSE cycle, motion overrun, or dwell expiry
    always_comb begin
        tmr_lim = CNT_W'(TIMEOUT_CYCLES);
        case (state)
            PAUSE:   tmr_lim = CNT_W'(DEAD_CYCLES - 1);
            IDLE:    tmr_lim = CNT_W'(DWELL_CYCLES - 1);
            default: ;
        endcase
    end

    assign tmr_en  = (state != FAULT);
    assign tmr_clr = (state_nxt != state) || ((state == IDLE) && !dwell_ok);

    door_cycle_timer #(.W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .clear    (tmr_clr),
        .enable   (tmr_en),
        .limit    (tmr_lim),
        .at_limit (tmr_hit)
    );

    always_comb begin
        state_nxt     = state;
        pause_dir_nxt = pause_dir;
        case (state)
            IDLE: begin
                if (both_lim) begin
                    state_nxt = FAULT;
                end else if (req_evt) begin
                    if (DN_MAX) begin
                        state_nxt = MV_UP;
                    end else if (UP_Max) begin
                        state_nxt = MV_DN;
                    end else begin
                        state_nxt = PAUSE;
                        if (last_dir == DIR_DN) begin
                            pause_dir_nxt = DIR_UP;
                        end else begin
                            pause_dir_nxt = DIR_DN;
                        end
                    end
                end
`ifdef AUTO_CLOSE_EN
                else if (dwell_ok && tmr_hit) begin
                    state_nxt = MV_DN;
                end
`endif
            end
            MV_UP: begin
                if (both_lim || tmr_hit) begin
                    state_nxt = FAULT;
                end else if (UP_Max || req_evt) begin
                    state_nxt = IDLE;
                end
            end
            MV_DN: begin
                // obstacle outranks both a stop request and the closed limit
                if (both_lim || tmr_hit) begin
                    state_nxt = FAULT;
                end else if (Obstacle) begin
                    state_nxt     = PAUSE;
                    pause_dir_nxt = DIR_UP;
                end else if (DN_MAX || req_evt) begin
                    state_nxt = IDLE;
                end
            end
            PAUSE: begin
                if (both_lim) begin
                    state_nxt = FAULT;
                end else if (tmr_hit) begin
                    if (pause_dir == DIR_UP) begin
                        state_nxt = MV_UP;
                    end else begin
                        state_nxt = MV_DN;
                    end
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = FAULT;
        endcase
    end

    assign UP_M  = (state == MV_UP);
    assign DN_M  = (state == MV_DN);
    assign Fault = (state == FAULT);

endmodule

// File: tb/tb_door_motion_sequencer.sv
// Directed bench for door_motion_sequencer with a cycle-level behavioural model checked every cycle.
module tb_door_motion_sequencer;

    localparam int DEAD = 4;
    localparam int TO   = 50;
    localparam int DW   = 20;

    logic CLK        = 1'b0;
    logic RST        = 1'b1;
    logic Act_Wall   = 1'b0;
    logic Act_Remote = 1'b0;
    logic UP_Max     = 1'b0;
    logic DN_MAX     = 1'b0;
    logic Obstacle   = 1'b0;
    logic UP_M, DN_M, Fault;

    int n_chk  = 0;
    int n_fail = 0;

    door_motion_sequencer #(
        .DEAD_CYCLES    (DEAD),
        .TIMEOUT_CYCLES (TO),
        .DWELL_CYCLES   (DW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Act_Wall   (Act_Wall),
        .Act_Remote (Act_Remote),
        .UP_Max     (UP_Max),
        .DN_MAX     (DN_MAX),
        .Obstacle   (Obstacle),
        .UP_M       (UP_M),
        .DN_M       (DN_M),
        .Fault      (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: motion as -1/0/+1, pause as cycles remaining, motor-on time as a run length
    int m_mot   = 0;
    int m_pause = 0;
    int m_pto   = 0;
    int m_on    = 0;
    int m_last  = -1;
    int m_dwell = 0;
    bit m_fault = 1'b0;
    bit m_pw    = 1'b0;
    bit m_pr    = 1'b0;
    bit m_armed = 1'b0;
    bit m_evt   = 1'b0;

    task start_motion(input int d);
        m_mot   = d;
        m_last  = d;
        m_pause = 0;
        m_on    = 0;
    endtask

    task go_fault();
        m_fault = 1'b1;
        m_mot   = 0;
        m_pause = 0;
    endtask

    initial forever begin
        @(posedge CLK or negedge RST);
        if (!RST) begin
            m_mot = 0; m_pause = 0; m_pto = 0; m_on = 0; m_last = -1; m_dwell = 0;
            m_fault = 1'b0; m_pw = 1'b0; m_pr = 1'b0; m_armed = 1'b0;
        end else begin
            m_evt   = m_armed && ((Act_Wall && !m_pw) || (Act_Remote && !m_pr));
            m_pw    = Act_Wall;
            m_pr    = Act_Remote;
            m_armed = 1'b1;
            if (m_fault) begin
                m_fault = 1'b1;
            end else if (UP_Max && DN_MAX) begin
                go_fault();
            end else if (m_pause > 0) begin
                if (m_pause == 1) start_motion(m_pto);
                else m_pause--;
            end else if (m_mot != 0) begin
                m_on++;
                if (m_on > TO) begin
                    go_fault();
                end else if (m_mot == -1 && Obstacle) begin
                    m_mot = 0; m_pause = DEAD; m_pto = 1;
                end else if ((m_mot == 1 && UP_Max) || (m_mot == -1 && DN_MAX) || m_evt) begin
                    m_mot = 0; m_dwell = 0;
                end
            end else begin
                if (m_evt) begin
                    if (DN_MAX) start_motion(1);
                    else if (UP_Max) start_motion(-1);
                    else begin
                        m_pause = DEAD; m_pto = -m_last;
                    end
                end
`ifdef AUTO_CLOSE_EN
                else if (UP_Max && !Obstacle) begin
                    m_dwell++;
                    if (m_dwell >= DW) start_motion(-1);
                end else begin
                    m_dwell = 0;
                end
`endif
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        check("model_up_m",  UP_M,  (!m_fault && m_pause == 0 && m_mot == 1));
        check("model_dn_m",  DN_M,  (!m_fault && m_pause == 0 && m_mot == -1));
        check("model_fault", Fault, m_fault);
        check("motor_excl",  UP_M & DN_M, 1'b0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    initial begin
        #1 RST = 1'b0;
        Act_Wall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_up_m", UP_M, 1'b0);
            check("rst_dn_m", DN_M, 1'b0);
            check("rst_fault", Fault, 1'b0);
        end
        RST = 1'b1;
        tick(3);
        check("held_req_up", UP_M, 1'b0);
        check("held_req_dn", DN_M, 1'b0);

        // open from closed, stop at open limit
        Act_Wall = 1'b0; DN_MAX = 1'b1; tick(1);
        Act_Remote = 1'b1; tick(1);
        check("open_start", UP_M, 1'b1);
        DN_MAX = 1'b0; tick(9);
        check("opening", UP_M, 1'b1);
        UP_Max = 1'b1; tick(1);
        check("open_stop", UP_M, 1'b0);
        Act_Remote = 1'b0;

        // close, obstacle on 5th cycle, dead time, reopen
        Act_Wall = 1'b1; tick(1);
        check("close_start", DN_M, 1'b1);
        UP_Max = 1'b0; tick(4);
        Obstacle = 1'b1; tick(1);
        check("obst_dn_off", DN_M, 1'b0);
        check("obst_up_off", UP_M, 1'b0);
        Obstacle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("dead_up", UP_M, 1'b0);
            check("dead_dn", DN_M, 1'b0);
        end
        tick(1);
        check("reopen", UP_M, 1'b1);
        UP_Max = 1'b1; Act_Wall = 1'b0; tick(1);
        check("reopen_stop", UP_M, 1'b0);

        // simultaneous edges mid-travel: one pause, then close (last motion was up)
        UP_Max = 1'b0; tick(1);
        Act_Wall = 1'b1; Act_Remote = 1'b1; tick(1);
        check("sim_pause_up", UP_M, 1'b0);
        check("sim_pause_dn", DN_M, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("sim_dead_dn", DN_M, 1'b0);
        end
        tick(1);
        check("sim_move_dn", DN_M, 1'b1);
        check("sim_move_up", UP_M, 1'b0);
        tick(2);
        check("sim_no_toggle", DN_M, 1'b1);
        Act_Wall = 1'b0; Act_Remote = 1'b0; tick(1);
        Act_Wall = 1'b1; tick(1);
        check("mid_stop", DN_M, 1'b0);

        // timeout: 51 motor-on cycles then fault
        Act_Wall = 1'b0; tick(1);
        Act_Wall = 1'b1; tick(1);
        check("to_pause", UP_M, 1'b0);
        tick(4);
        check("to_start", UP_M, 1'b1);
        tick(50);
        check("to_cycle50", UP_M, 1'b1);
        tick(1);
        check("to_fault", Fault, 1'b1);
        check("to_motor_off", UP_M, 1'b0);
        Act_Wall = 1'b0; DN_MAX = 1'b1; tick(1);
        Act_Remote = 1'b1; tick(2);
        check("fault_latched", Fault, 1'b1);
        check("fault_no_move", UP_M, 1'b0);
        RST = 1'b0; #1;
        check("fault_rst_async", Fault, 1'b0);
        Act_Remote = 1'b0;
        tick(1);
        RST = 1'b1; tick(1);
        Act_Wall = 1'b1; tick(1);
        check("post_rst_open", UP_M, 1'b1);
        RST = 1'b0; #1;
        check("rst_async_motor", UP_M, 1'b0);
        tick(1);
        RST = 1'b1; Act_Wall = 1'b0; DN_MAX = 1'b0;
        tick(2);

        // both limits at once
        UP_Max = 1'b1; DN_MAX = 1'b1; tick(1);
        check("both_lim_fault", Fault, 1'b1);
        RST = 1'b0; tick(1);
        RST = 1'b1; DN_MAX = 1'b0; tick(1);

`ifdef AUTO_CLOSE_EN
        tick(9);
        Obstacle = 1'b1; tick(1);
        Obstacle = 1'b0; tick(19);
        check("dwell_wait", DN_M, 1'b0);
        tick(1);
        check("auto_close", DN_M, 1'b1);
`else
        tick(30);
        check("stay_open", DN_M, 1'b0);
`endif
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/door_motion_sequencer.md
DOOR_MOTION_SEQUENCER -- requirements
Module: door_motion_sequencer

Interface
REQ-001 Parameter DEAD_CYCLES, default 8: motor-off cycles required before any direction reversal.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum cycles in one motion state before fault.
REQ-003 Parameter DWELL_CYCLES, default 500: cycles fully open before auto-close (AUTO_CLOSE_EN only).
REQ-004 Port CLK input 1: single clock; all state changes on rising edge.
REQ-005 Port RST input 1: asynchronous, active-low reset.
REQ-006 Port Act_Wall input 1: wall-button request, level, rising edge is the event.
REQ-007 Port Act_Remote input 1: remote request, level, rising edge is the event.
REQ-008 Port UP_Max input 1: door fully open limit switch, active-high.
REQ-009 Port DN_MAX input 1: door fully closed limit switch, active-high.
REQ-010 Port Obstacle input 1: beam-break sensor, active-high.
REQ-011 Port UP_M output 1: open-motor drive.
REQ-012 Port DN_M output 1: close-motor drive.
REQ-013 Port Fault output 1: latched fault indication.

Function
REQ-014 States SHALL be IDLE, MV_UP, MV_DN, PAUSE, FAULT; UP_M=1 only in MV_UP, DN_M=1 only in MV_DN, Fault=1 only in FAULT; all outputs decoded from the state register (Moore).
REQ-015 A request event SHALL be a rising edge on Act_Wall or Act_Remote against its previous-cycle registered value; simultaneous edges on both SHALL count as one event.
REQ-016 IDLE + event: DN_MAX=1 -> MV_UP; UP_Max=1 -> MV_DN; neither -> PAUSE then direction opposite to last motion (reset value of last direction = DN, so first mid-travel request opens).
REQ-017 Motor output SHALL assert on the rising CLK edge at which the event is sampled (one-cycle latency from input edge to output).
REQ-018 Event in MV_UP or MV_DN SHALL go to IDLE (stop mid-travel) on the next edge.
REQ-019 MV_UP with UP_Max=1 -> IDLE; MV_DN with DN_MAX=1 -> IDLE.
REQ-020 Obstacle=1 in MV_DN SHALL go to PAUSE then MV_UP, overriding a same-cycle event or DN_MAX; Obstacle is ignored in all other states.
REQ-021 PAUSE SHALL last exactly DEAD_CYCLES cycles with both motors off; events during PAUSE are ignored.
REQ-022 Direct MV_UP<->MV_DN transition SHALL never occur; UP_M and DN_M SHALL never be 1 in the same cycle.
REQ-023 Counter exceeding TIMEOUT_CYCLES in MV_UP or MV_DN, or UP_Max=1 and DN_MAX=1 together in any state, SHALL enter FAULT.
REQ-024 FAULT SHALL be exited only by reset.
REQ-025 The cycle counter SHALL clear on every state change and saturate at its maximum value (no wrap).

Reset
REQ-026 RST=0 SHALL asynchronously force IDLE, counter=0, last direction=DN, edge registers=0, UP_M=DN_M=Fault=0.
REQ-027 Reset asserted mid-motion SHALL drop the motor output immediately, without waiting for CLK.
REQ-028 After RST release a request input already high SHALL NOT generate an event.

Configuration
REQ-029 Macro AUTO_CLOSE_EN defined: IDLE with UP_Max=1 and Obstacle=0 for DWELL_CYCLES consecutive cycles -> MV_DN; Obstacle=1 restarts the dwell count.
REQ-030 Macro AUTO_CLOSE_EN undefined: door remains open indefinitely; DWELL_CYCLES unused.

Structure
REQ-031 Package door_pkg SHALL hold the state enumeration and default values of DEAD_CYCLES, TIMEOUT_CYCLES and DWELL_CYCLES.
REQ-032 Sub-module door_cycle_timer (clear, enable, saturating count, compare-to-limit flag) SHALL serve pause, timeout and dwell timing.

Verification (DEAD_CYCLES=4, TIMEOUT_CYCLES=50, DWELL_CYCLES=20)
REQ-033 RST=0 for 3 cycles with Act_Wall=1 -> UP_M=DN_M=Fault=0; release reset, Act_Wall held high -> remains IDLE.
REQ-034 DN_MAX=1, Act_Remote 0->1 -> UP_M=1 next edge; UP_Max=1 after 10 cycles -> UP_M=0 next edge, IDLE.
REQ-035 UP_Max=1, event -> DN_M=1; Obstacle=1 at cycle 5 -> DN_M=0, 4 cycles both off, then UP_M=1.
REQ-036 Motion with no limit for 51 cycles -> Fault=1, motors 0; further events ignored until RST=0.
REQ-037 Simultaneous Act_Wall and Act_Remote edges mid-travel in IDLE -> single PAUSE of 4 cycles then one motion start, no toggle back.
REQ-038 AUTO_CLOSE_EN defined: UP_Max=1 idle 20 cycles -> DN_M=1; Obstacle pulse at cycle 10 -> DN_M delayed until 20 cycles after pulse.
